// File: rtl/am_lock_tracker_pkg.sv
// am_lock_tracker_pkg: AM patterns, idle block, FSM states and BIP3 helper
// shared by the alignment-marker lock tracker.
package am_lock_tracker_pkg;

    localparam logic [1:0]  CTRL_SH    = 2'b10;
    localparam logic [65:0] IDLE_BLOCK = {CTRL_SH, 8'h1E, 56'h0};

    typedef enum logic [1:0] {ST_SEARCH, ST_CONFIRM, ST_LOCK} state_e;

    // {M0, M1, M2} per PCS lane
    localparam logic [23:0] AM_TABLE_100G [20] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    localparam logic [23:0] AM_TABLE_40G [4] = '{
        24'h907647, 24'hF0C4E6, 24'hC5659B, 24'hA2793D
    };

    function automatic logic [7:0] bip3_of(input logic [65:0] blk);
        logic [7:0] b;
        b = {3'b000, blk[65], blk[64], 3'b000};
        for (int k = 0; k < 8; k++) b ^= blk[8*k +: 8];
        return b;
    endfunction

endpackage

// File: rtl/am_lock_tracker_bip3_accumulator.sv
// am_lock_tracker_bip3_accumulator: running BIP3 over coded blocks; load restarts
// the parity from the current block.
module am_lock_tracker_bip3_accumulator
    import am_lock_tracker_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [65:0] data_i,
    output logic [7:0]  bip_o
);

    logic [7:0] acc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) acc_q <= '0;
        else if (en_i) acc_q <= load_i ? bip3_of(data_i) : acc_q ^ bip3_of(data_i);
    end

    assign bip_o = acc_q;

endmodule

// File: rtl/am_lock_tracker.sv
// am_lock_tracker: per-lane 100G/40G PCS alignment-marker lock, AM-slot idle substitution
// and lane ID report. Define AM_BIP_CHECK_EN to enable BIP3 checking on locked AMs.
module am_lock_tracker
    import am_lock_tracker_pkg::*;
#(
    parameter int NB_CODED_BLOCK   = 66,
    parameter int N_LANES          = 20,
    parameter int NB_LANE_ID       = $clog2(N_LANES),
    parameter int AM_PERIOD        = 16384,
    parameter int NB_PERIOD        = $clog2(AM_PERIOD),
    parameter int NB_VAL_AM        = 5,
    parameter int NB_INV_AM        = 3,
    parameter int NB_ERROR_COUNTER = 32
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_valid,
    input  logic                        i_block_lock,
    input  logic [NB_CODED_BLOCK-1:0]   i_data,
    input  logic [N_LANES-1:0]          i_lane_search_msk,
    input  logic [NB_VAL_AM-1:0]        i_valid_am_thr,
    input  logic [NB_INV_AM-1:0]        i_invalid_am_thr,
    output logic [NB_CODED_BLOCK-1:0]   o_data,
    output logic                        o_valid,
    output logic [NB_LANE_ID-1:0]       o_lane_id,
    output logic                        o_am_lock,
    output logic                        o_resync,
    output logic                        o_start_of_lane,
    output logic                        o_bip_error,
    output logic [NB_ERROR_COUNTER-1:0] o_error_counter
);

    state_e                    state_q;
    logic [NB_CODED_BLOCK-1:0] data_q;
    logic                      valid_q, resync_q, sol_q;
    logic [NB_LANE_ID-1:0]     lane_id_q, hit_id;
    logic [NB_PERIOD-1:0]      cnt_q, cnt_d;
    logic [NB_VAL_AM-1:0]      valid_cnt_q, valid_cnt_d, val_thr;
    logic [NB_INV_AM-1:0]      inv_cnt_q, inv_cnt_d, inv_thr;
    logic [N_LANES-1:0]        lane_match, search_hits;
    logic                      advance, am_form, cur_match, slot, replace, lose;

    assign advance = i_enable && i_valid;
    assign am_form = (i_data[65:64] == CTRL_SH) && (i_data[31:8] == ~i_data[63:40]);

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        localparam logic [23:0] PAT = (N_LANES == 4) ? AM_TABLE_40G[l % 4] : AM_TABLE_100G[l % 20];
        assign lane_match[l] = am_form && (i_data[63:40] == PAT);
    end

    assign search_hits = lane_match & i_lane_search_msk;

    always_comb begin
        hit_id = '0;
        for (int l = N_LANES - 1; l >= 0; l--)
            if (search_hits[l]) hit_id = NB_LANE_ID'(l);
    end

    // The AM slot is the block on which the period counter sits at zero
    assign cur_match   = lane_match[lane_id_q];
    assign slot        = (state_q != ST_SEARCH) && (cnt_q == '0);
    assign replace     = (state_q == ST_LOCK) && slot && i_block_lock;
    assign cnt_d       = (cnt_q == NB_PERIOD'(AM_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    assign valid_cnt_d = valid_cnt_q + 1'b1;
    assign inv_cnt_d   = inv_cnt_q + 1'b1;
    assign val_thr     = i_valid_am_thr | NB_VAL_AM'(i_valid_am_thr == '0);
    assign inv_thr     = i_invalid_am_thr | NB_INV_AM'(i_invalid_am_thr == '0);
    assign lose        = replace && !cur_match && (inv_cnt_d >= inv_thr);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_SEARCH;
            data_q      <= '0;
            valid_q     <= 1'b0;
            resync_q    <= 1'b0;
            sol_q       <= 1'b0;
            lane_id_q   <= '0;
            cnt_q       <= '0;
            valid_cnt_q <= '0;
            inv_cnt_q   <= '0;
        end else begin
            valid_q  <= advance;
            resync_q <= advance && (state_q == ST_LOCK) && (!i_block_lock || lose);
            sol_q    <= advance && replace;
            if (advance) begin
                data_q <= replace ? IDLE_BLOCK : i_data;
                if (!i_block_lock) begin
                    state_q     <= ST_SEARCH;
                    cnt_q       <= '0;
                    valid_cnt_q <= '0;
                    inv_cnt_q   <= '0;
                end else begin
                    case (state_q)
                        ST_SEARCH: if (|search_hits) begin
                            lane_id_q   <= hit_id;
                            cnt_q       <= NB_PERIOD'(1);
                            valid_cnt_q <= NB_VAL_AM'(1);
                            state_q     <= (val_thr == NB_VAL_AM'(1)) ? ST_LOCK : ST_CONFIRM;
                        end
                        ST_CONFIRM: begin
                            cnt_q <= cnt_d;
                            if (slot && cur_match) begin
                                valid_cnt_q <= valid_cnt_d;
                                if (valid_cnt_d >= val_thr) state_q <= ST_LOCK;
                            end else if (slot) begin
                                state_q     <= ST_SEARCH;
                                cnt_q       <= '0;
                                valid_cnt_q <= '0;
                            end
                        end
                        ST_LOCK: begin
                            cnt_q <= cnt_d;
                            if (slot) inv_cnt_q <= cur_match ? '0 : inv_cnt_d;
                            if (lose) begin
                                state_q     <= ST_SEARCH;
                                cnt_q       <= '0;
                                valid_cnt_q <= '0;
                                inv_cnt_q   <= '0;
                            end
                        end
                        default: state_q <= ST_SEARCH;
                    endcase
                end
            end
        end
    end

    assign o_data          = data_q;
    assign o_valid         = valid_q;
    assign o_lane_id       = lane_id_q;
    assign o_am_lock       = (state_q == ST_LOCK);
    assign o_resync        = resync_q;
    assign o_start_of_lane = sol_q;

`ifdef AM_BIP_CHECK_EN
    logic [7:0]                  bip_acc;
    logic                        bip_err_q, bip_load, bip_bad;
    logic [NB_ERROR_COUNTER-1:0] err_cnt_q;

    // Parity restarts on every AM slot and on the AM that starts a search capture
    assign bip_load = slot || ((state_q == ST_SEARCH) && i_block_lock && (|search_hits));
    assign bip_bad  = advance && replace && cur_match && (bip_acc != i_data[39:32]);

    am_lock_tracker_bip3_accumulator u_bip3 (
        .clk_i  (i_clock),
        .rst_i  (i_reset),
        .en_i   (advance),
        .load_i (bip_load),
        .data_i (i_data),
        .bip_o  (bip_acc)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bip_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            bip_err_q <= bip_bad;
            if (bip_bad && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign o_bip_error     = bip_err_q;
    assign o_error_counter = err_cnt_q;
`else
    assign o_bip_error     = 1'b0;
    assign o_error_counter = '0;
`endif

endmodule

// File: tb/tb_am_lock_tracker.sv
// tb_am_lock_tracker: randomized stream of AM periods checked cycle by cycle against a
// behavioural lock model, plus directed lock/unlock/mask/reset/BIP scenarios.
module tb_am_lock_tracker;

    localparam int P = 32;
    localparam logic [65:0] IDLE = {2'b10, 8'h1E, 56'h0};
    localparam logic [23:0] AMT [20] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };
`ifdef AM_BIP_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, vld, blk;
    logic [65:0] din;
    logic [19:0] msk;
    logic [4:0]  vthr;
    logic [2:0]  ithr;
    logic [65:0] o_data;
    logic        o_valid, o_am_lock, o_resync, o_sol, o_berr;
    logic [4:0]  o_lane_id;
    logic [31:0] o_ecnt;

    int          checks = 0, failures = 0, n_resync = 0, n_sol = 0;
    int          mode, lane, since, good, bad;
    logic [65:0] e_data;
    bit          e_valid, e_lock, e_resync, e_sol, e_berr;
    logic [31:0] e_ecnt;
    logic [7:0]  gen_acc = '0;
`ifdef AM_BIP_CHECK_EN
    logic [7:0]  m_acc;
`endif

    always #5 clk = ~clk;

    am_lock_tracker #(.AM_PERIOD(P)) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_enable          (en),
        .i_valid           (vld),
        .i_block_lock      (blk),
        .i_data            (din),
        .i_lane_search_msk (msk),
        .i_valid_am_thr    (vthr),
        .i_invalid_am_thr  (ithr),
        .o_data            (o_data),
        .o_valid           (o_valid),
        .o_lane_id         (o_lane_id),
        .o_am_lock         (o_am_lock),
        .o_resync          (o_resync),
        .o_start_of_lane   (o_sol),
        .o_bip_error       (o_berr),
        .o_error_counter   (o_ecnt)
    );

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bip(input logic [65:0] b);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 8; k++) r[j] ^= b[8*k + j];
        r[3] ^= b[64];
        r[4] ^= b[65];
        return r;
    endfunction

    function automatic bit is_am(input logic [65:0] b, input int l);
        return b[65:64] == 2'b10 && b[63:40] == AMT[l] && b[31:8] == ~AMT[l];
    endfunction

    function automatic logic [65:0] rand_blk();
        return {($urandom_range(1) != 0) ? 2'b01 : 2'b10, $urandom, $urandom};
    endfunction

    // mode: 0 searching, 1 confirming, 2 locked; since = blocks after the anchoring AM
    task automatic model_step();
        int  vt, it, fl, prev;
        bit  slot, m, found, repl;
        if (rst) begin
            mode = 0; lane = 0; since = 0; good = 0; bad = 0;
            e_data = '0; e_valid = 0; e_resync = 0; e_sol = 0; e_berr = 0; e_ecnt = '0; e_lock = 0;
`ifdef AM_BIP_CHECK_EN
            m_acc = '0;
`endif
            return;
        end
        e_valid = en && vld; e_resync = 0; e_sol = 0; e_berr = 0;
        if (!e_valid) return;
        vt = (vthr == 0) ? 1 : int'(vthr);
        it = (ithr == 0) ? 1 : int'(ithr);
        prev = mode;
        slot = (mode != 0) && ((since + 1) % P == 0);
        m = slot && is_am(din, lane);
        repl = (prev == 2) && slot && blk;
        e_data = repl ? IDLE : din;
        e_sol = repl;
        found = 0; fl = 0;
        for (int l = 0; l < 20; l++)
            if (!found && msk[l] && is_am(din, l)) begin found = 1; fl = l; end
`ifdef AM_BIP_CHECK_EN
        if (repl && m && m_acc != din[39:32]) begin
            e_berr = 1;
            if (e_ecnt != '1) e_ecnt = e_ecnt + 1;
        end
        m_acc = (slot || (mode == 0 && blk && found)) ? bip(din) : m_acc ^ bip(din);
`endif
        if (!blk) begin
            e_resync = (prev == 2);
            mode = 0; since = 0; good = 0; bad = 0;
        end else if (mode == 0) begin
            if (found) begin
                lane = fl; since = 0; good = 1; bad = 0;
                mode = (vt <= 1) ? 2 : 1;
            end
        end else begin
            since++;
            if (slot && mode == 1) begin
                if (m) begin
                    good++;
                    if (good >= vt) mode = 2;
                end else mode = 0;
            end else if (slot) begin
                if (m) bad = 0;
                else begin
                    bad++;
                    if (bad >= it) begin mode = 0; bad = 0; e_resync = 1; end
                end
            end
        end
        e_lock = (mode == 2);
    endtask

    task automatic step(input logic [65:0] d, input bit v, input bit e, input bit b);
        din = d; vld = v; en = e; blk = b;
        @(posedge clk);
        model_step();
        #1;
        chk("o_data", o_data, e_data);
        chk("o_valid", 66'(o_valid), 66'(e_valid));
        chk("o_lane_id", 66'(o_lane_id), 66'(lane));
        chk("o_am_lock", 66'(o_am_lock), 66'(e_lock));
        chk("o_resync", 66'(o_resync), 66'(e_resync));
        chk("o_start_of_lane", 66'(o_sol), 66'(e_sol));
        chk("o_bip_error", 66'(o_berr), 66'(e_berr));
        chk("o_error_counter", 66'(o_ecnt), 66'(e_ecnt));
        if (o_resync) n_resync++;
        if (o_sol) n_sol++;
    endtask

    task automatic blk_out(input logic [65:0] d);
        int r;
        r = $urandom_range(15);
        if (r == 0) step(rand_blk(), 0, 1, 1);
        else if (r == 1) step(rand_blk(), 1, 0, 1);
        step(d, 1, 1, 1);
    endtask

    // One AM period: AM (or a plain block when l < 0) followed by P-1 data blocks
    task automatic period(input int l, input bit bad_am, input bit flip);
        logic [65:0] d;
        if (l < 0) d = rand_blk();
        else d = {2'b10, AMT[l], gen_acc, ~AMT[l], 8'($urandom)};
        if (bad_am) d[8] = ~d[8];
        gen_acc = bip(d);
        blk_out(d);
        for (int i = 1; i < P; i++) begin
            d = rand_blk();
            gen_acc ^= bip(d);
            if (flip && i == P / 2) d[$urandom_range(63)] ^= 1'b1;
            blk_out(d);
        end
    endtask

    initial begin
        rst = 1; en = 0; vld = 0; blk = 1; din = '0;
        msk = 20'hFFFFF; vthr = 5'd4; ithr = 3'd4;
        repeat (3) step(rand_blk(), 1, 1, 1);
        rst = 0;

        repeat (5) period(5, 0, 0);
        chk("s1_lock", 66'(o_am_lock), 66'(1));
        chk("s1_lane", 66'(o_lane_id), 66'(5));
        chk("s1_sol_count", 66'(n_sol), 66'(1));

        repeat (3) period(5, 1, 0);
        period(5, 0, 0);
        chk("s2_hold", 66'(o_am_lock), 66'(1));
        n_resync = 0;
        repeat (4) period(5, 1, 0);
        chk("s2_resync_count", 66'(n_resync), 66'(1));
        chk("s2_unlock", 66'(o_am_lock), 66'(0));

        n_resync = 0;
        repeat (2) period(5, 0, 0);
        period(6, 0, 0);
        period(-1, 0, 0);
        chk("s3_lock", 66'(o_am_lock), 66'(0));
        chk("s3_resync_count", 66'(n_resync), 66'(0));

        msk = 20'h00010;
        repeat (5) period(3, 0, 0);
        chk("s4_nolock", 66'(o_am_lock), 66'(0));
        repeat (5) period(4, 0, 0);
        chk("s4_lock", 66'(o_am_lock), 66'(1));
        chk("s4_lane", 66'(o_lane_id), 66'(4));

        for (int i = 0; i < P / 2; i++) blk_out(rand_blk());
        step(rand_blk(), 1, 1, 0);
        chk("s5_resync", 66'(o_resync), 66'(1));
        chk("s5_unlock", 66'(o_am_lock), 66'(0));
        repeat (2) period(4, 0, 0);
        rst = 1;
        step(rand_blk(), 1, 1, 1);
        chk("s5_rst_valid", 66'(o_valid), 66'(0));
        chk("s5_rst_data", o_data, 66'(0));
        chk("s5_rst_lane", 66'(o_lane_id), 66'(0));
        chk("s5_rst_lock", 66'(o_am_lock), 66'(0));
        rst = 0;

        msk = 20'hFFFFF;
        repeat (5) period(5, 0, 0);
        period(5, 0, 1);
        repeat (2) period(5, 0, 0);
        chk("s6_error_counter", 66'(o_ecnt), 66'(EXP_ERR));

        repeat (30) begin
            int l, n;
            case ($urandom_range(3))
                0: l = 3;
                1: l = 5;
                2: l = 7;
                default: l = -1;
            endcase
            msk = 20'($urandom) | 20'h000A8;
            if ($urandom_range(3) == 0) msk[l < 0 ? 0 : l] = 1'b0;
            vthr = 5'($urandom_range(2, 5));
            ithr = 3'($urandom_range(0, 4));
            n = $urandom_range(1, 8);
            repeat (n) period(l, $urandom_range(3) == 0, $urandom_range(5) == 0);
            if ($urandom_range(9) == 0) step(rand_blk(), 1, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
